// File: rtl/lp_pkg.sv
// rtl/lp_pkg.sv - shared types and helpers for the multi-channel low-pass filter
// Purpose: sequencer state encoding, bypass threshold and accumulator overflow decode.
// Ports: none (package).
package lp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lp_state_e;

    // Largest tau for which y = acc >>> (shift+tau) still spans the sample range.
    function automatic int tau_max(input int s, input int shift, input int r);
        return s - shift - r;
    endfunction

    // Decode the top two bits of an (S+1)-bit sum that must fit S bits.
    function automatic logic ovf_pos(input logic [1:0] top2);
        return top2 == 2'b01;
    endfunction

    function automatic logic ovf_neg(input logic [1:0] top2);
        return top2 == 2'b10;
    endfunction

endpackage

// File: rtl/lp_section.sv
// rtl/lp_section.sv - one combinational first-order IIR section update
// Purpose: acc_n = clamp(x - (acc >>> k) + acc), y = clamp(acc_n >>> k), k = SHIFT+tau.
// Ports: acc_i current accumulator, x_i section input, tau_i exponent, bypass_i pass x through;
//        acc_n_o next accumulator, y_o section output, sat_o a clamp happened.
module lp_section
    import lp_pkg::*;
#(
    parameter int R     = 14,
    parameter int S     = 58,
    parameter int SHIFT = 14
) (
    input  logic signed [S-1:0] acc_i,
    input  logic signed [R-1:0] x_i,
    input  logic [5:0]          tau_i,
    input  logic                bypass_i,
    output logic signed [S-1:0] acc_n_o,
    output logic signed [R-1:0] y_o,
    output logic                sat_o
);
    localparam int DW = S - SHIFT;
    localparam logic signed [S-1:0] ACC_MAX = {1'b0, {(S-1){1'b1}}};
    localparam logic signed [S-1:0] ACC_MIN = {1'b1, {(S-1){1'b0}}};
    localparam logic signed [R-1:0] Y_MAX   = {1'b0, {(R-1){1'b1}}};
    localparam logic signed [R-1:0] Y_MIN   = {1'b1, {(R-1){1'b0}}};

    logic signed [DW-1:0] d;
    logic signed [S:0]    sum;
    logic signed [S-1:0]  acc_c;
    logic signed [S-1:0]  y_sh;
    logic [S-R:0]         y_hi;
    logic                 acc_clamp;
    logic                 y_clamp;

    always_comb begin
        d         = DW'(acc_i >>> (SHIFT + int'(tau_i)));
        sum       = (S+1)'(x_i) - (S+1)'(d) + (S+1)'(acc_i);
        acc_clamp = ovf_pos(sum[S:S-1]) | ovf_neg(sum[S:S-1]);
        if (ovf_pos(sum[S:S-1])) begin
            acc_c = ACC_MAX;
        end else if (ovf_neg(sum[S:S-1])) begin
            acc_c = ACC_MIN;
        end else begin
            acc_c = sum[S-1:0];
        end
        y_sh = acc_c >>> (SHIFT + int'(tau_i));
        // y fits R bits only when all bits above the sign position agree
        y_hi    = y_sh[S-1:R-1];
        y_clamp = !((&y_hi) || !(|y_hi));
        if (y_clamp) begin
            y_o = y_sh[S-1] ? Y_MIN : Y_MAX;
        end else begin
            y_o = y_sh[R-1:0];
        end
        acc_n_o = acc_c;
        sat_o   = acc_clamp | y_clamp;
        if (bypass_i) begin
            acc_n_o = acc_i;
            y_o     = x_i;
            sat_o   = 1'b0;
        end
    end

endmodule

// File: rtl/lp_filter_mc.sv
// rtl/lp_filter_mc.sv - time-multiplexed multi-channel multi-order IIR low-pass filter
// Purpose: one shared section datapath stepped over CH channels x stages sections per sample.
// Ports: clk, rst (sync, active-high); tau, stages, in_valid, in (ch0 in LSBs), clr_flags;
//        busy, out (registered), out_valid (1-cycle pulse), sat (sticky per channel), overrun (sticky).
module lp_filter_mc
    import lp_pkg::*;
#(
    parameter int R     = 14,
    parameter int CH    = 4,
    parameter int ORDER = 2,
    parameter int S     = 58,
    parameter int SHIFT = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      tau,
    input  logic [1:0]      stages,
    input  logic            in_valid,
    input  logic [CH*R-1:0] in,
    input  logic            clr_flags,
    output logic            busy,
    output logic [CH*R-1:0] out,
    output logic            out_valid,
    output logic [CH-1:0]   sat,
    output logic            overrun
);
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int NA   = CH * ORDER;
    localparam int AW   = (NA > 1) ? $clog2(NA) : 1;
    localparam int TMAX = tau_max(S, SHIFT, R);

    lp_state_e            state_q, state_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [1:0]           st_q, st_d;
    logic [CH*R-1:0]      in_q;
    logic [5:0]           tau_q;
    logic [1:0]           stages_q;
    logic                 bypass_q;
    logic signed [S-1:0]  acc_q [NA];
    logic signed [R-1:0]  carry_q;
    logic [CH*R-1:0]      out_q;
    logic [CH-1:0]        sat_q;
    logic                 overrun_q;

    logic                 accept;
    logic                 last_st;
    logic                 last_ch;
    logic [1:0]           stages_eff;
    logic [AW-1:0]        idx;
    logic signed [R-1:0]  x_sel;
    logic signed [R-1:0]  y;
    logic signed [S-1:0]  acc_n;
    logic                 sec_sat;
    logic [CH-1:0]        sat_set;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        st_d       = st_q;
        accept     = 1'b0;
        stages_eff = (stages > 2'(ORDER)) ? 2'(ORDER) : stages;
        last_st    = (st_q == stages_q - 2'd1);
        last_ch    = (ch_q == CW'(CH - 1));
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (in_valid) begin
                    accept  = 1'b1;
                    ch_d    = '0;
                    st_d    = '0;
                    state_d = (stages_eff == 2'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_st) begin
                    st_d = '0;
                    if (last_ch) begin
                        state_d = ST_DONE;
                    end else begin
                        ch_d = ch_q + CW'(1);
                    end
                end else begin
                    st_d = st_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Section 0 takes the latched channel sample; later sections chain the previous y.
    always_comb begin
        idx     = AW'(ch_q) * AW'(ORDER) + AW'(st_q);
        x_sel   = (st_q == 2'd0) ? in_q[ch_q*R +: R] : carry_q;
        sat_set = (state_q == ST_RUN && sec_sat) ? (CH'(1) << ch_q) : '0;
    end

    lp_section #(
        .R     (R),
        .S     (S),
        .SHIFT (SHIFT)
    ) u_section (
        .acc_i    (acc_q[idx]),
        .x_i      (x_sel),
        .tau_i    (tau_q),
        .bypass_i (bypass_q),
        .acc_n_o  (acc_n),
        .y_o      (y),
        .sat_o    (sec_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            st_q      <= '0;
            in_q      <= '0;
            tau_q     <= '0;
            stages_q  <= '0;
            bypass_q  <= 1'b0;
            carry_q   <= '0;
            out_q     <= '0;
            sat_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NA; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            st_q    <= st_d;
            if (accept) begin
                in_q     <= in;
                tau_q    <= tau;
                stages_q <= stages_eff;
                bypass_q <= (tau > 6'(TMAX));
                if (stages_eff == 2'd0) begin
                    out_q <= in;
                end
            end
            if (state_q == ST_RUN) begin
                if (!bypass_q) begin
                    acc_q[idx] <= acc_n;
                end
                carry_q <= y;
                if (last_st) begin
                    out_q[ch_q*R +: R] <= y;
                end
            end
            // a new event in the same cycle outweighs a clear
            sat_q     <= (sat_q & ~{CH{clr_flags}}) | sat_set;
            overrun_q <= (overrun_q & ~clr_flags) | (in_valid && state_q == ST_RUN);
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign out       = out_q;
    assign out_valid = (state_q == ST_DONE);
    assign sat       = sat_q;
    assign overrun   = overrun_q;

endmodule
